// File: rtl/ecsm_seq_ctrl_if.sv
// Command channel between the scalar-multiplication sequencer and the point-arithmetic unit.
// The sequencer is the master: it drives op_valid/op_code and receives op_ready/op_done.
interface ecsm_seq_ctrl_if;
    logic       op_valid;
    logic [1:0] op_code;
    logic       op_ready;
    logic       op_done;

    modport master (
        output op_valid,
        output op_code,
        input  op_ready,
        input  op_done
    );

    modport slave (
        input  op_valid,
        input  op_code,
        output op_ready,
        output op_done
    );
endinterface

// File: rtl/ecsm_seq_ctrl.sv
// Double-and-add sequencer: scans scalar k MSB-first and issues LOAD/DBL/ADD/INV commands
// to the point-arithmetic unit, one command in flight at a time.
module ecsm_seq_ctrl #(
    parameter int unsigned BW_GF = 256,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned CNT_W = 10
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic [BW_GF-1:0]  k,
    output logic              busy,
    ecsm_seq_ctrl_if.master   op_if,
    output logic              is_first,
    output logic [IDX_W-1:0]  bit_idx,
    output logic [CNT_W-1:0]  op_cnt,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] OpLoad = 2'd0;
    localparam logic [1:0] OpDbl  = 2'd1;
    localparam logic [1:0] OpAdd  = 2'd2;
    localparam logic [1:0] OpInv  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StIssue,
        StWait,
        StNext,
        StFin
    } state_e;

    state_e             state_q, state_d;
    logic [BW_GF-1:0]   k_reg_q, k_reg_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;
    logic [1:0]         op_code_q, op_code_d;
    logic               op_valid_q, op_valid_d;
    logic               busy_q, busy_d;
    logic               is_first_q, is_first_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               cur_bit;
    logic               at_lsb;

    assign cur_bit = k_reg_q[bit_idx_q];
    assign at_lsb  = (bit_idx_q == '0);

    always_comb begin
        state_d    = state_q;
        k_reg_d    = k_reg_q;
        bit_idx_d  = bit_idx_q;
        op_cnt_d   = op_cnt_q;
        op_code_d  = op_code_q;
        op_valid_d = op_valid_q;
        busy_d     = busy_q;
        is_first_d = is_first_q;
        done_d     = 1'b0;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                // done_q high means this is the completion cycle; start is not taken there.
                if (start && !done_q) begin
                    k_reg_d    = k;
                    bit_idx_d  = IDX_W'(BW_GF - 1);
                    op_cnt_d   = '0;
                    is_first_d = 1'b1;
                    busy_d     = 1'b1;
                    if (k == '0) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                if (cur_bit) begin
                    op_code_d  = OpLoad;
                    op_valid_d = 1'b1;
                    state_d    = StIssue;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end
            StIssue: begin
                if (op_if.op_ready) begin
                    op_valid_d = 1'b0;
                    if (op_cnt_q != '1) begin
                        op_cnt_d = op_cnt_q + 1'b1;
                    end
                    if (op_code_q == OpLoad) begin
                        is_first_d = 1'b0;
                    end
                    state_d = StWait;
                end
            end
            StWait: begin
                if (op_if.op_done) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                op_valid_d = 1'b1;
                state_d    = StIssue;
                unique case (op_code_q)
                    OpLoad, OpAdd: begin
                        if (at_lsb) begin
                            op_code_d = OpInv;
                        end else begin
                            bit_idx_d = bit_idx_q - 1'b1;
                            op_code_d = OpDbl;
                        end
                    end
                    OpDbl: begin
                        // The bit just doubled into still needs its conditional add.
                        if (cur_bit) begin
                            op_code_d = OpAdd;
                        end else if (at_lsb) begin
                            op_code_d = OpInv;
                        end else begin
                            bit_idx_d = bit_idx_q - 1'b1;
                            op_code_d = OpDbl;
                        end
                    end
                    OpInv: begin
                        op_valid_d = 1'b0;
                        state_d    = StFin;
                    end
                    default: begin
                        op_valid_d = 1'b0;
                        state_d    = StIdle;
                    end
                endcase
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= StIdle;
            k_reg_q    <= '0;
            bit_idx_q  <= '0;
            op_cnt_q   <= '0;
            op_code_q  <= OpLoad;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            is_first_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_reg_q    <= k_reg_d;
            bit_idx_q  <= bit_idx_d;
            op_cnt_q   <= op_cnt_d;
            op_code_q  <= op_code_d;
            op_valid_q <= op_valid_d;
            busy_q     <= busy_d;
            is_first_q <= is_first_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign op_if.op_valid = op_valid_q;
    assign op_if.op_code  = op_code_q;
    assign busy           = busy_q;
    assign is_first       = is_first_q;
    assign bit_idx        = bit_idx_q;
    assign op_cnt         = op_cnt_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: doc/ecsm_seq_ctrl.md
Name: ecsm_seq_ctrl

Overview:
- Double-and-add sequencer for the 256-bit EC scalar-multiplication datapath.
- Latches scalar k on start and scans it MSB-first.
- Issues LOAD / DBL / ADD / INV commands to the point-arithmetic unit over a valid/ready command channel with a done return.
- Signals completion to the top-level ECDH wrapper.

Parameters:
- BW_GF, 256, scalar width in bits.
- IDX_W, 8, bit-index width; must satisfy 2^IDX_W >= BW_GF.
- CNT_W, 10, width of the issued-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- srst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- k  in  BW_GF  scalar; sampled when start is accepted.
- busy  out  1  high in every state except IDLE.
- op_valid  out  1  command valid to the point unit.
- op_code  out  2  command: 0 LOAD (acc=P), 1 DBL (acc=2acc), 2 ADD (acc=acc+P), 3 INV (projective->affine).
- op_ready  in  1  point unit accepts the command this cycle.
- op_done  in  1  one-cycle pulse: the accepted command has finished.
- is_first  out  1  high from start acceptance until LOAD is accepted.
- bit_idx  out  IDX_W  index of the scalar bit currently being processed.
- op_cnt  out  CNT_W  count of commands accepted since the last start.
- done  out  1  one-cycle completion pulse.
- err  out  1  result is the point at infinity (k==0); holds until next start.

Behaviour:
- Reset (srst=1 at an edge):
  - state=IDLE.
  - busy=0, op_valid=0, op_code=0, is_first=0, bit_idx=0, op_cnt=0, done=0, err=0.
  - Applies from any state, including mid-handshake; the point unit must be reset alongside.
- States: IDLE, SCAN, ISSUE, WAIT, NEXT, FIN.
- IDLE:
  - start=1 latches k_reg=k, sets bit_idx=BW_GF-1, clears op_cnt and err, sets is_first=1.
  - If k==0: next state FIN with err=1. Otherwise next state SCAN.
- SCAN (leading-zero skip, one bit per cycle):
  - k_reg[bit_idx]==0: bit_idx decrements, stay in SCAN.
  - k_reg[bit_idx]==1: op_code=LOAD, go to ISSUE.
  - bit_idx never underflows, because k!=0 is guaranteed here.
- ISSUE:
  - op_valid=1; op_code is stable while op_valid is high.
  - Command is accepted on a cycle with op_valid&op_ready. On acceptance: op_valid falls next cycle, op_cnt increments (saturating at all-ones), state goes to WAIT.
  - If LOAD is accepted, is_first clears.
- WAIT:
  - op_valid=0; on op_done go to NEXT.
  - op_done is ignored outside WAIT, including an op_done arriving in the same cycle as acceptance.
- NEXT (one cycle, decides the following command):
  - Finished LOAD or ADD: if bit_idx==0, issue INV. Else decrement bit_idx and issue DBL.
  - Finished DBL: if k_reg[bit_idx]==1 issue ADD; else if bit_idx==0 issue INV; else decrement bit_idx and issue DBL.
  - Finished INV: go to FIN.
- FIN: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- Per-bit order: DBL precedes ADD for every bit below the MSB. Command count = 1 LOAD + (msb_pos) DBL + (popcount(k)-1) ADD + 1 INV.
- start while busy is ignored: k_reg is unchanged and no restart occurs.
- start in the same cycle as done is ignored; start is accepted from the following IDLE cycle.
- op_ready high outside ISSUE has no effect.
- Latency, with zero-wait point unit (op_ready=1, op_done the cycle after acceptance):
  - SCAN takes BW_GF-1-msb_pos cycles plus 1.
  - Each command takes 3 cycles (ISSUE, WAIT, NEXT).

Test Plan:
- k=1, zero-wait unit -> 255 SCAN cycles, then LOAD, INV; op_cnt=2; single done pulse; err=0.
- k=0 -> no op_valid ever; err=1 and done pulse 2 cycles after start; busy=1 for 1 cycle.
- k=0xB -> command sequence LOAD, DBL, DBL, ADD, DBL, ADD, INV; op_cnt=7; bit_idx=0 at INV.
- k=all ones -> 1 LOAD, 255 DBL, 255 ADD, 1 INV, alternating DBL/ADD; op_cnt=512 (within CNT_W=10).
- op_ready held low 5 cycles per command, plus a spurious op_done during ISSUE -> op_valid/op_code stable throughout, spurious op_done ignored, sequence identical to zero-wait case.
- srst mid-WAIT on k=0xB, then start with k=2 within busy window before reset -> returns to IDLE with all outputs zero; start during busy is ignored; new run gives LOAD, DBL, INV.
